icache: RTL and testbench

- Direct-mapped instruction cache between the fetcher and the memory controller.
- Serves one 32-bit instruction per fetcher request.
- On a miss, issues one 128-bit line request to the memory controller's fetch port (pc, enable, finish, inst_block) and installs the returned line.
- Handles fetcher rollback while a refill is outstanding, without cancelling the memory controller.

---
 rtl/icache_pkg.sv | 34 +++
 rtl/icache_if.sv | 25 ++
 rtl/icache_line_array.sv | 42 ++++
 rtl/icache.sv | 121 ++++++++++++
 tb/tb_icache.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared geometry and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_NUM = 16;
  localparam int INDEX_W  = 4;
  localparam int BLOCK_W  = 128;
  localparam int ADDR_W   = 32;
  localparam int TAG_W    = 24;

  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [BLOCK_W-1:0] block_t;

  function automatic tag_t get_tag(input logic [ADDR_W-1:0] pc);
    return pc[31:8];
  endfunction

  function automatic index_t get_index(input logic [ADDR_W-1:0] pc);
    return pc[7:4];
  endfunction

  function automatic logic [31:0] get_word(input block_t line, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      2'd3:    w = line[127:96];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher and memory-controller fetch-port signals seen by the instruction cache.
interface icache_if;
  import icache_pkg::*;

  logic              rdy;
  logic              rollback;
  logic [ADDR_W-1:0] pc_from_fch;
  logic              valid_from_fch;
  logic              hit_to_fch;
  logic [31:0]       inst_to_fch;
  logic              enable_sign_to_mem;
  logic [ADDR_W-1:0] pc_to_mem;
  logic              finish_sign_from_mem;
  block_t            inst_block_from_mem;

  modport slave (
    input  rdy, rollback, pc_from_fch, valid_from_fch, finish_sign_from_mem, inst_block_from_mem,
    output hit_to_fch, inst_to_fch, enable_sign_to_mem, pc_to_mem
  );

  modport master (
    output rdy, rollback, pc_from_fch, valid_from_fch, finish_sign_from_mem, inst_block_from_mem,
    input  hit_to_fch, inst_to_fch, enable_sign_to_mem, pc_to_mem
  );
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the icache: one write port, combinational read,
// valid bits cleared synchronously on rst.
module icache_line_array
  import icache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  index_t i_rd_index,
  output logic   o_rd_valid,
  output tag_t   o_rd_tag,
  output block_t o_rd_data,
  input  logic   i_we,
  input  index_t i_wr_index,
  input  tag_t   i_wr_tag,
  input  block_t i_wr_data
);

  logic [LINE_NUM-1:0] r_valid;
  tag_t                r_tag  [LINE_NUM];
  block_t              r_data [LINE_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (!rst && i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache controller (IDLE/MISS/DRAIN).
// Optional hit/miss counters are built when ICACHE_STAT_EN is defined.
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  icache_if.slave     bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MISS  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_hit;
  logic [31:0]       r_inst;
  logic              r_en;
  logic [ADDR_W-1:0] r_pc_mem;

  logic   w_rd_valid;
  tag_t   w_rd_tag;
  block_t w_rd_data;
  logic   w_lookup_hit;
  logic   w_accept;
  logic   w_we;

  icache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (get_index(bus.pc_from_fch)),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_we),
    .i_wr_index (get_index(r_pc)),
    .i_wr_tag   (get_tag(r_pc)),
    .i_wr_data  (bus.inst_block_from_mem)
  );

  assign w_lookup_hit = w_rd_valid && (w_rd_tag == get_tag(bus.pc_from_fch));
  // A request raised together with rollback is dropped outright.
  assign w_accept     = bus.rdy && (r_state == S_IDLE) && bus.valid_from_fch && !bus.rollback;
  assign w_we         = bus.rdy && bus.finish_sign_from_mem &&
                        ((r_state == S_MISS) || (r_state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_hit    <= 1'b0;
      r_inst   <= 32'd0;
      r_en     <= 1'b0;
      r_pc_mem <= '0;
    end else if (bus.rdy) begin
      r_hit <= 1'b0;
      r_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_lookup_hit) begin
            r_hit  <= 1'b1;
            r_inst <= get_word(w_rd_data, bus.pc_from_fch[3:2]);
          end else if (w_accept) begin
            r_pc     <= bus.pc_from_fch;
            r_en     <= 1'b1;
            r_pc_mem <= {bus.pc_from_fch[31:4], 4'b0000};
            r_state  <= S_MISS;
          end
        end
        S_MISS: begin
          if (bus.finish_sign_from_mem) begin
            r_state <= S_IDLE;
            if (!bus.rollback) begin
              r_hit  <= 1'b1;
              r_inst <= get_word(bus.inst_block_from_mem, r_pc[3:2]);
            end
          end else if (bus.rollback) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.finish_sign_from_mem) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STAT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (w_accept && w_lookup_hit) begin
      r_hit_cnt  <= r_hit_cnt + 32'd1;
    end else if (w_accept) begin
      r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif

  assign bus.hit_to_fch         = r_hit;
  assign bus.inst_to_fch        = r_inst;
  assign bus.enable_sign_to_mem = r_en;
  assign bus.pc_to_mem          = r_pc_mem;

endmodule

// File: tb/tb_icache.sv
// Directed-vector bench for icache: cold miss, hits, eviction, rollback, rdy stall, reset mid-miss.
module tb_icache;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   hit_seen;

  icache_if bus_if ();

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_s;
  logic [31:0] miss_cnt_s;
`endif

  icache u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
`ifdef ICACHE_STAT_EN
    ,
    .o_hit_cnt  (hit_cnt_s),
    .o_miss_cnt (miss_cnt_s)
`endif
  );

  localparam logic [127:0] L0 = {32'h00B00113, 32'h00A00093, 32'h22222222, 32'h11111111};
  localparam logic [127:0] L1 = {32'h44444444, 32'h33333333, 32'hBBBB0000, 32'hAAAA0000};
  localparam logic [127:0] L2 = {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h09090909};
  localparam logic [127:0] L3 = {32'h83838383, 32'h82828282, 32'h81818181, 32'h80808080};
  localparam logic [127:0] L4 = {32'h23002300, 32'h22002200, 32'h21002100, 32'h20002000};
  localparam logic [127:0] L5 = {32'h53535353, 32'h52525252, 32'h51515151, 32'h50505050};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] pc);
    bus_if.valid_from_fch = 1'b1;
    bus_if.pc_from_fch    = pc;
    tick();
    bus_if.valid_from_fch = 1'b0;
  endtask

  task automatic fill(input logic [127:0] line);
    bus_if.finish_sign_from_mem = 1'b1;
    bus_if.inst_block_from_mem  = line;
    tick();
    bus_if.finish_sign_from_mem = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_if.rdy = 1'b1;
    bus_if.rollback = 1'b0;
    bus_if.pc_from_fch = 32'd0;
    bus_if.valid_from_fch = 1'b0;
    bus_if.finish_sign_from_mem = 1'b0;
    bus_if.inst_block_from_mem = 128'd0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_hit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    check_eq("rst_inst", bus_if.inst_to_fch, 32'd0);
    check_eq("rst_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd0);
    check_eq("rst_pcmem", bus_if.pc_to_mem, 32'd0);

    // Cold miss
    req(32'h00000008);
    check_eq("cold_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    check_eq("cold_pcmem", bus_if.pc_to_mem, 32'h00000000);
    check_eq("cold_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    tick();
    check_eq("cold_en_once", {31'd0, bus_if.enable_sign_to_mem}, 32'd0);
    fill(L0);
    check_eq("cold_fill_hit", {31'd0, bus_if.hit_to_fch}, 32'd1);
    check_eq("cold_fill_inst", bus_if.inst_to_fch, 32'h00A00093);
    tick();
    check_eq("cold_hit_pulse", {31'd0, bus_if.hit_to_fch}, 32'd0);

    // Hit after fill, then back-to-back hits
    req(32'h0000000C);
    check_eq("hit_w3", {31'd0, bus_if.hit_to_fch}, 32'd1);
    check_eq("hit_w3_inst", bus_if.inst_to_fch, 32'h00B00113);
    check_eq("hit_w3_noen", {31'd0, bus_if.enable_sign_to_mem}, 32'd0);
    bus_if.valid_from_fch = 1'b1;
    bus_if.pc_from_fch = 32'h00000000;
    tick();
    check_eq("b2b_w0", bus_if.inst_to_fch, 32'h11111111);
    bus_if.pc_from_fch = 32'h00000004;
    tick();
    check_eq("b2b_w1_hit", {31'd0, bus_if.hit_to_fch}, 32'd1);
    check_eq("b2b_w1", bus_if.inst_to_fch, 32'h22222222);
    bus_if.valid_from_fch = 1'b0;
    tick();

    // Conflict eviction on index 0
    req(32'h00000100);
    check_eq("evict_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    check_eq("evict_pcmem", bus_if.pc_to_mem, 32'h00000100);
    tick();
    fill(L1);
    check_eq("evict_inst", bus_if.inst_to_fch, 32'hAAAA0000);
    tick();
    req(32'h00000000);
    check_eq("evict_remiss", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    check_eq("evict_remiss_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    check_eq("evict_remiss_pc", bus_if.pc_to_mem, 32'h00000000);
    tick();
    fill(L0);
    check_eq("evict_refill_inst", bus_if.inst_to_fch, 32'h11111111);
    tick();

    // Rollback in MISS, then finish: no response, line still installed
    req(32'h00000048);
    check_eq("rb_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    tick();
    tick();
    bus_if.rollback = 1'b1;
    tick();
    bus_if.rollback = 1'b0;
    tick();
    fill(L2);
    check_eq("rb_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    tick();
    check_eq("rb_nohit2", {31'd0, bus_if.hit_to_fch}, 32'd0);
    req(32'h00000044);
    check_eq("rb_after_hit", {31'd0, bus_if.hit_to_fch}, 32'd1);
    check_eq("rb_after_inst", bus_if.inst_to_fch, 32'h0A0A0A0A);
    check_eq("rb_after_noen", {31'd0, bus_if.enable_sign_to_mem}, 32'd0);

    // Rollback in IDLE drops a simultaneous request
    bus_if.rollback = 1'b1;
    req(32'h00000040);
    bus_if.rollback = 1'b0;
    check_eq("rb_idle_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);

    // Rollback together with finish in MISS
    req(32'h00000080);
    check_eq("rbf_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    tick();
    bus_if.rollback = 1'b1;
    fill(L3);
    bus_if.rollback = 1'b0;
    check_eq("rbf_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    req(32'h00000080);
    check_eq("rbf_hit", {31'd0, bus_if.hit_to_fch}, 32'd1);
    check_eq("rbf_inst", bus_if.inst_to_fch, 32'h80808080);

    // rdy stall across the finish-to-hit boundary
    req(32'h00000200);
    check_eq("stall_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    tick();
    bus_if.rdy = 1'b0;
    bus_if.finish_sign_from_mem = 1'b1;
    bus_if.inst_block_from_mem = L4;
    hit_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.hit_to_fch) hit_seen++;
    end
    check_eq("stall_nohit", hit_seen, 32'd0);
    bus_if.rdy = 1'b1;
    tick();
    bus_if.finish_sign_from_mem = 1'b0;
    check_eq("stall_hit", {31'd0, bus_if.hit_to_fch}, 32'd1);
    check_eq("stall_inst", bus_if.inst_to_fch, 32'h20002000);
    tick();
    check_eq("stall_once", {31'd0, bus_if.hit_to_fch}, 32'd0);

    // Reset mid-MISS, stale finish ignored
    req(32'h00000300);
    check_eq("rmm_en", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rmm_en_clr", {31'd0, bus_if.enable_sign_to_mem}, 32'd0);
    fill(L5);
    check_eq("rmm_stale_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    req(32'h00000300);
    check_eq("rmm_remiss", {31'd0, bus_if.enable_sign_to_mem}, 32'd1);
    check_eq("rmm_remiss_nohit", {31'd0, bus_if.hit_to_fch}, 32'd0);
    tick();
    fill(L5);
    check_eq("rmm_fill_inst", bus_if.inst_to_fch, 32'h50505050);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
